// File: rtl/fc_layer_accum_if.sv
// Stream/result bundle between the FC accumulator and its neighbours.
// The master side feeds activations, weight columns and biases and takes z[];
// the slave side is the accumulator itself.
interface fc_layer_accum_if #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_NODES  = 500
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_x;
  logic signed [DATA_WIDTH-1:0] in_w [NUM_NODES];
  logic                         in_last;
  logic signed [DATA_WIDTH-1:0] in_b [NUM_NODES];
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] z    [NUM_NODES];
  logic                         len_err;

  modport master (
    output in_valid, in_x, in_w, in_last, in_b, out_ready,
    input  in_ready, out_valid, z, len_err
  );

  modport slave (
    input  in_valid, in_x, in_w, in_last, in_b, out_ready,
    output in_ready, out_valid, z, len_err
  );
endinterface

// File: rtl/fc_layer_accum.sv
// Fully-connected layer accumulator: one activation per beat is multiplied by
// the matching weight column into NUM_NODES parallel accumulators; after the
// last beat the bias is added, the sum is saturated to DATA_WIDTH and held on
// z[] for the ReLU layer until it is taken.
module fc_layer_accum #(
  parameter int DATA_WIDTH = 24,
  parameter int FRAC_BITS  = 12,
  parameter int ACC_WIDTH  = 40,
  parameter int NUM_NODES  = 500,
  parameter int NUM_INPUTS = 784
) (
  input logic           clk,
  input logic           rst_n,
  fc_layer_accum_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_INPUTS) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);

  // Saturation bounds expressed in the widened bias-sum width.
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] Z_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] Z_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ACCUM, BIAS, HOLD} state_t;

  state_t           state;
  state_t           next_state;
  logic             accept;
  logic             bias_cycle;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             len_err_q;
  logic [CNT_W-1:0] beat_cnt;

  logic signed [ACC_WIDTH-1:0]    acc       [NUM_NODES];
  logic signed [DATA_WIDTH-1:0]   z_q       [NUM_NODES];
  logic signed [2*DATA_WIDTH-1:0] product   [NUM_NODES];
  logic signed [ACC_WIDTH-1:0]    prod_term [NUM_NODES];
  logic signed [ACC_WIDTH:0]      biased    [NUM_NODES];
  logic signed [DATA_WIDTH-1:0]   sat_val   [NUM_NODES];

  // State register; reset lands in ACCUM so a fresh vector can start at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: a vector ends only on an accepted in_last beat.
  always_comb begin
    next_state = state;
    case (state)
      ACCUM:   if (accept && bus.in_last) next_state = BIAS;
      BIAS:    next_state = HOLD;
      HOLD:    if (bus.out_ready) next_state = ACCUM;
      default: next_state = ACCUM;
    endcase
  end

  // Per-state control strobes; accept honours the registered ready so nothing
  // is taken in the first cycle after reset.
  always_comb begin
    accept     = 1'b0;
    bias_cycle = 1'b0;
    case (state)
      ACCUM:   accept = bus.in_valid && in_ready_q;
      BIAS:    bias_cycle = 1'b1;
      default: ;
    endcase
  end

  // Handshake flags are registered from next_state so neither has a
  // combinational path from out_ready; beat counting and the sticky length error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      beat_cnt    <= '0;
      len_err_q   <= 1'b0;
    end else begin
      in_ready_q  <= (next_state == ACCUM);
      out_valid_q <= (next_state == HOLD);
      if (accept) begin
        beat_cnt <= bus.in_last ? '0 : beat_cnt + CNT_W'(1);
        if (bus.in_last != (beat_cnt == LAST_IDX)) len_err_q <= 1'b1;
      end
    end
  end

  // Per-node arithmetic: full-width product floored by the arithmetic shift,
  // wrapped to the accumulator width, then bias sum widened by one bit and clamped.
  always_comb begin
    for (int n = 0; n < NUM_NODES; n++) begin
      product[n]   = (2*DATA_WIDTH)'(bus.in_x) * (2*DATA_WIDTH)'(bus.in_w[n]);
      prod_term[n] = ACC_WIDTH'(product[n] >>> FRAC_BITS);
      biased[n]    = (ACC_WIDTH+1)'(acc[n]) + (ACC_WIDTH+1)'(bus.in_b[n]);
      if (biased[n] > SAT_MAX) begin
        sat_val[n] = Z_MAX;
      end else if (biased[n] < SAT_MIN) begin
        sat_val[n] = Z_MIN;
      end else begin
        sat_val[n] = biased[n][DATA_WIDTH-1:0];
      end
    end
  end

  // Accumulators grow on accepted beats; the bias cycle captures z[] and
  // clears the sums for the next vector. z[] is otherwise left untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_NODES; n++) begin
        acc[n] <= '0;
        z_q[n] <= '0;
      end
    end else if (accept) begin
      for (int n = 0; n < NUM_NODES; n++) acc[n] <= acc[n] + prod_term[n];
    end else if (bias_cycle) begin
      for (int n = 0; n < NUM_NODES; n++) begin
        z_q[n] <= sat_val[n];
        acc[n] <= '0;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.len_err   = len_err_q;
  assign bus.z         = z_q;

endmodule
